// File: rtl/jg_video_pkg.sv
// Shared definitions for the tile-layer video fetch path: fetch FSM states,
// attribute bit positions and tile geometry.
package jg_video_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAP,
    ATTR,
    GFX0,
    GFX1,
    DONE
  } fetch_state_t;

  localparam int ATTR_CODE8 = 5;
  localparam int ATTR_FLIPX = 6;
  localparam int ATTR_FLIPY = 7;
  localparam int TILE_W     = 8;

  // Mirror a plane row so the rightmost pixel is shifted out first.
  function automatic logic [TILE_W-1:0] bit_rev(input logic [TILE_W-1:0] d);
    for (int i = 0; i < TILE_W; i++) begin
      bit_rev[i] = d[TILE_W-1-i];
    end
  endfunction

endpackage

// File: rtl/jg_tile_fetch_if.sv
// Read-only memory bus between the tile fetcher and the tile/attribute RAMs
// and the graphics ROM; every read returns data one clock after the address.
interface jg_tile_fetch_if #(
  parameter int GFX_AW = 13
);

  logic [9:0]        vram_addr;
  logic [7:0]        vram_q;
  logic [9:0]        cram_addr;
  logic [7:0]        cram_q;
  logic [GFX_AW-1:0] gfx_addr;
  logic [7:0]        gfx_q;

  modport master (
    output vram_addr,
    output cram_addr,
    output gfx_addr,
    input  vram_q,
    input  cram_q,
    input  gfx_q
  );

  modport slave (
    input  vram_addr,
    input  cram_addr,
    input  gfx_addr,
    output vram_q,
    output cram_q,
    output gfx_q
  );

endinterface

// File: rtl/jg_tile_shifter.sv
// Two 8-bit plane shift registers plus the colour latch for the tile being
// displayed; loads on the last pixel of a slot, otherwise shifts on ce.
module jg_tile_shifter
  import jg_video_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              load,
  input  logic              rev,
  input  logic [TILE_W-1:0] plane0,
  input  logic [TILE_W-1:0] plane1,
  input  logic [4:0]        colour_in,
  output logic              bit0,
  output logic              bit1,
  output logic [4:0]        colour
);

  logic [TILE_W-1:0] sh0_p0;
  logic [TILE_W-1:0] sh1_p0;

  // Display stage: shifter contents for the current tile
  always_ff @(posedge clk) begin
    if (reset) begin
      sh0_p0 <= '0;
      sh1_p0 <= '0;
      colour <= '0;
    end else if (ce) begin
      if (load) begin
        sh0_p0 <= rev ? bit_rev(plane0) : plane0;
        sh1_p0 <= rev ? bit_rev(plane1) : plane1;
        colour <= colour_in;
      end else begin
        sh0_p0 <= {sh0_p0[TILE_W-2:0], 1'b0};
        sh1_p0 <= {sh1_p0[TILE_W-2:0], 1'b0};
      end
    end
  end

  assign bit0 = sh0_p0[TILE_W-1];
  assign bit1 = sh1_p0[TILE_W-1];

endmodule

// File: rtl/jg_tile_fetch.sv
// Tile-layer fetcher: per 8-pixel slot reads code, attribute and two plane
// bytes for the next column, then feeds the pixel shifters.
module jg_tile_fetch
  import jg_video_pkg::*;
#(
  parameter int HBITS  = 9,
  parameter int GFX_AW = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [HBITS-1:0] hcount,
  input  logic [HBITS-1:0] vcount,
  input  logic             vid_blank,
  input  logic             flip,
  jg_tile_fetch_if.master  mem,
  output logic [6:0]       pix
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic              start;
  logic              load;
  logic [4:0]        target;
  logic [4:0]        col;
  logic [7:0]        ey;
  logic [9:0]        tile_addr;
  logic [2:0]        ey_fine;
  logic [8:0]        code_now;
  logic [2:0]        fine_now;
  logic [8:0]        code_p0;
  logic [2:0]        fine_p0;
  logic [4:0]        colour_p0;
  logic              flipx_p0;
  logic [7:0]        plane0_p1;
  logic [7:0]        buf_plane0;
  logic [7:0]        buf_plane1;
  logic [4:0]        buf_colour;
  logic              buf_flipx;
  logic [GFX_AW-1:0] gfx_addr_r;
  logic              bit0;
  logic              bit1;
  logic [4:0]        act_colour;
  logic              unused_hi;

  function automatic logic [GFX_AW-1:0] gfx_word(input logic [8:0] code,
                                                 input logic [2:0] fine,
                                                 input logic       plane);
    gfx_word = GFX_AW'({code, fine, plane});
  endfunction

  assign unused_hi = ^{hcount[HBITS-1:8], vcount[HBITS-1:8]};

  assign start  = ce_pix && (hcount[2:0] == 3'd0);
  assign load   = ce_pix && (hcount[2:0] == 3'd7);
  assign target = hcount[7:3] + 5'd1;
  assign col    = target ^ {5{flip}};
  assign ey     = vcount[7:0] ^ {8{flip}};

  assign code_now = {mem.cram_q[ATTR_CODE8], mem.vram_q};
  assign fine_now = ey_fine ^ {3{mem.cram_q[ATTR_FLIPY]}};

  assign mem.vram_addr = tile_addr;
  assign mem.cram_addr = tile_addr;
  assign mem.gfx_addr  = gfx_addr_r;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new slot start always wins, abandoning any fetch still in flight.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = MAP;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        MAP:     state_next = ATTR;
        ATTR:    state_next = GFX0;
        GFX0:    state_next = GFX1;
        GFX1:    state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Fetch stage: addresses and per-tile latches
  always_ff @(posedge clk) begin
    if (reset) begin
      tile_addr  <= '0;
      ey_fine    <= '0;
      code_p0    <= '0;
      fine_p0    <= '0;
      colour_p0  <= '0;
      flipx_p0   <= 1'b0;
      gfx_addr_r <= '0;
      plane0_p1  <= '0;
    end else if (start) begin
      tile_addr <= {ey[7:3], col};
      ey_fine   <= ey[2:0];
    end else begin
      case (state)
        ATTR: begin
          code_p0    <= code_now;
          fine_p0    <= fine_now;
          colour_p0  <= mem.cram_q[4:0];
          flipx_p0   <= mem.cram_q[ATTR_FLIPX];
          gfx_addr_r <= gfx_word(code_now, fine_now, 1'b0);
        end
        GFX0:    gfx_addr_r <= gfx_word(code_p0, fine_p0, 1'b1);
        GFX1:    plane0_p1  <= mem.gfx_q;
        default: ;
      endcase
    end
  end

  // Buffer stage: only a completed fetch updates the next-tile buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_plane0 <= '0;
      buf_plane1 <= '0;
      buf_colour <= '0;
      buf_flipx  <= 1'b0;
    end else if (!start && state == DONE) begin
      buf_plane0 <= plane0_p1;
      buf_plane1 <= mem.gfx_q;
      buf_colour <= colour_p0;
      buf_flipx  <= flipx_p0;
    end
  end

  jg_tile_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce_pix),
    .load      (load),
    .rev       (buf_flipx ^ flip),
    .plane0    (buf_plane0),
    .plane1    (buf_plane1),
    .colour_in (buf_colour),
    .bit0      (bit0),
    .bit1      (bit1),
    .colour    (act_colour)
  );

  // Output stage: one registered colour index per pixel enable
  always_ff @(posedge clk) begin
    if (reset)       pix <= '0;
    else if (ce_pix) pix <= vid_blank ? 7'd0 : {act_colour, bit1, bit0};
  end

endmodule
